// File: rtl/queue_requester_if.sv
// Handshake bundle between a queue_requester and its environment: local push
// port, arbiter request/grant pair, shared-bus transfer and status flags.
interface queue_requester_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
);
  logic                       push_valid;
  logic [DATA_W-1:0]          push_data;
  logic                       push_ready;
  logic                       req;
  logic                       gnt;
  logic                       bus_valid;
  logic [DATA_W-1:0]          bus_data;
  logic [$clog2(DEPTH+1)-1:0] pending;
  logic                       stray_gnt;
  logic                       timeout_err;

  modport master (
    input  push_valid, push_data, gnt,
    output push_ready, req, bus_valid, bus_data, pending, stray_gnt, timeout_err
  );

  modport slave (
    output push_valid, push_data, gnt,
    input  push_ready, req, bus_valid, bus_data, pending, stray_gnt, timeout_err
  );
endinterface

// File: rtl/queue_requester.sv
// Requester agent for the two-way queue arbiter: FIFO-buffered requests, one transfer per grant.
// Optional macro REQ_TIMEOUT_EN adds a grant-wait timeout with retry.
module queue_requester #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic              clock,
  input logic              reset,
  queue_requester_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_param_check
    $error("queue_requester: DEPTH must be a power of two >= 2 and MAX_WAIT >= 1");
  end

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     pending_q, pending_d;
  logic                req_q;
  logic                bus_valid_q, bus_valid_d;
  logic [DATA_W-1:0]   bus_data_q, bus_data_d;
  logic                stray_q, stray_d;
  logic                timeout_d;
  logic                push, pop, push_ready, gnt_s;

  // X or Z on the grant line must never start a transfer.
  assign gnt_s      = (bus.gnt === 1'b1);
  assign push_ready = (pending_q < CntW'(DEPTH));
  assign push       = bus.push_valid && push_ready;
  assign pending_d  = pending_q + CntW'(push) - CntW'(pop);

`ifdef REQ_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q;
`endif

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    stray_d     = 1'b0;
    timeout_d   = 1'b0;
    bus_valid_d = 1'b0;
    bus_data_d  = bus_data_q;
    unique case (state_q)
      StIdle: begin
        stray_d = gnt_s;
        if (pending_q != '0) state_d = StReq;
      end
      StReq: begin
        if (gnt_s) begin
          state_d     = StHold;
          pop         = 1'b1;
          bus_valid_d = 1'b1;
          bus_data_d  = mem_q[rptr_q];
        end
`ifdef REQ_TIMEOUT_EN
        else if (wait_q == WaitW'(MAX_WAIT - 1)) begin
          // Give up this round without popping; HOLD retries the same head.
          state_d   = StHold;
          timeout_d = 1'b1;
        end
`endif
      end
      StHold: begin
        stray_d = gnt_s;
        state_d = (pending_q != '0) ? StReq : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef REQ_TIMEOUT_EN
  always_comb begin
    wait_d = wait_q;
    if (state_d == StReq && state_q != StReq) begin
      wait_d = '0;
    end else if (state_q == StReq && !gnt_s) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      pending_q   <= '0;
      req_q       <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      req_q       <= (state_d == StReq);
      bus_valid_q <= bus_valid_d;
      bus_data_q  <= bus_data_d;
      stray_q     <= stray_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= bus.push_data;
  end

  assign bus.push_ready = push_ready;
  assign bus.req        = req_q;
  assign bus.bus_valid  = bus_valid_q;
  assign bus.bus_data   = bus_data_q;
  assign bus.pending    = pending_q;
  assign bus.stray_gnt  = stray_q;

  // Keeps the timeout flag from looking unused when the feature is compiled out.
  logic unused_timeout;
  assign unused_timeout = timeout_d;

endmodule

// File: doc/queue_requester.md
# queue_requester

Requester-side agent for the two-way queue arbiter: it buffers local transactions in a small FIFO, drives one arbiter request line, and waits for the matching grant line. On grant it issues the head entry onto the shared bus, then drops its request for one cycle so the arbiter can serve the other requester. One instance sits on each arbiter port, R0/G0 and R1/G1.

## Interface
- `DATA_W`, default 8: width of a transaction word.
- `DEPTH`, default 4: number of FIFO entries; must be a power of two, ≥2.
- `MAX_WAIT`, default 15: number of cycles without a grant before a timeout; used only with `REQ_TIMEOUT_EN`.
- `reset` in 1: asynchronous, active-low reset.
- `clock` in 1: clock, rising edge.
- `push_valid` in 1: local write strobe.
- `push_data` in DATA_W: local write data.
- `push_ready` out 1: FIFO can accept a write; equals `pending < DEPTH`.
- `req` out 1: request to the arbiter (Rn), registered.
- `gnt` in 1: grant from the arbiter (Gn); treat as 0 when X.
- `bus_valid` out 1: one-cycle transfer strobe on the shared bus, registered.
- `bus_data` out DATA_W: transfer data; holds its last value when `bus_valid`=0.
- `pending` out clog2(DEPTH+1): current FIFO occupancy, registered.
- `stray_gnt` out 1: one-cycle pulse when `gnt` is seen while not in REQ.
- `timeout_err` out 1: one-cycle pulse when a wait has timed out.

## Operation
- **Reset.** `reset` low clears all state immediately:
  - FIFO empty, `pending`=0, state IDLE.
  - `req`, `bus_valid`, `stray_gnt`, `timeout_err` = 0; `bus_data` = 0.
  - Reset mid-transfer discards every queued entry.
- **Push.** A write is accepted when `push_valid`=1 and `push_ready`=1. Writes while full are dropped silently.
  - `push_ready` depends only on the registered `pending`, so a full FIFO refuses a push even in a cycle where a pop occurs.
- **State machine**, states IDLE, REQ, HOLD:
  - IDLE → REQ when `pending`≠0.
  - REQ with `gnt`=1 → HOLD. At that edge: `bus_valid`←1, `bus_data`←head entry, pop.
  - REQ with `gnt`=0 → stays in REQ (see timeout).
  - HOLD → REQ if `pending`≠0 after the pop; otherwise HOLD → IDLE.
- **Outputs.**
  - `req` = 1 exactly while the state is REQ.
  - `bus_valid` is high for exactly one cycle, the first cycle of HOLD.
- **Occupancy arithmetic.** `pending` next = `pending` + push − pop, where push and pop are each 0 or 1. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- **Simultaneous push and pop.** `pending` is unchanged; the head data is the value that was correct before the edge.
- **Stray grant.** `gnt`=1 in IDLE or HOLD causes a `stray_gnt` pulse on the next cycle, with no pop and no bus activity.

## Timing
- Latency from push to request on an empty FIFO: push sampled at edge N; `pending`=1 after N; `req`=1 after N+1.
- Grant to bus: `gnt` sampled at edge M; `bus_valid`=1 during cycle M..M+1; `req`=0 in that same cycle.
- Back-to-back entries: `req` reasserts after edge M+1.
  - The minimum request period is 2 cycles, with one mandatory gap cycle.
- `gnt` is sampled only at the clock edge; combinational glitches between edges are ignored.

## Configuration
- Macro `REQ_TIMEOUT_EN` defined:
  - A wait counter of width clog2(MAX_WAIT+1) clears on entry to REQ and increments each REQ cycle with `gnt`=0.
  - When the counter equals MAX_WAIT−1 and `gnt`=0, the block pulses `timeout_err` for one cycle and goes REQ → HOLD without popping.
  - The entry is then retried from HOLD, because `pending`≠0.
  - A `gnt` arriving in the same cycle as the timeout edge wins: normal transfer, no error.
- Macro `REQ_TIMEOUT_EN` undefined:
  - No counter is built; `timeout_err` is tied to 0.
  - REQ waits indefinitely for `gnt`.

## Test plan
- **Reset and single transfer:** assert reset with 2 entries queued, then release; push 0xA5 with `gnt` tied 1 → `pending`=0, all outputs 0 after reset; `req` rises 2 edges after the push; `bus_valid`=1 with `bus_data`=0xA5 one cycle later; `pending` returns to 0.
- **Fill and overflow:** with DEPTH=4 and `gnt`=0, push 0x01..0x05 → `push_ready`=0 after the 4th push, `pending`=4, 0x05 dropped. Then toggle `gnt` → bus carries 0x01, 0x02, 0x03, 0x04 in order, with one `req`-low cycle between transfers.
- **Simultaneous push and pop:** at 3 entries, push 0x77 on the same edge as a grant → `pending` stays 3; 0x77 is emitted 3 grants later.
- **Stray grant:** pulse `gnt` while in IDLE with `pending`=0 → `stray_gnt`=1 for one cycle; `bus_valid` stays 0; `pending` stays 0.
- **Timeout** (`REQ_TIMEOUT_EN`, MAX_WAIT=15): hold `gnt`=0 for 15 REQ cycles → `timeout_err` pulses once, `req` drops for 1 cycle then re-rises, `pending` unchanged. Repeat with `gnt`=1 on cycle 15 → transfer occurs and `timeout_err` stays 0.
- **Reset mid-operation:** pull reset low during HOLD with 3 entries queued → `bus_valid`, `req` and `pending` clear asynchronously; no transfer follows after release.
